// File: rtl/debounce_pulse_if.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pulse_if
// Description : Button input and conditioned level/tick outputs of debounce_pulse.
// Revision    : 1.0 - initial release
// ============================================================================
interface debounce_pulse_if;
    logic btn_in;
    logic db_level;
    logic rise_tick;
    logic fall_tick;

    modport master (
        output btn_in,
        input  db_level,
        input  rise_tick,
        input  fall_tick
    );

    modport slave (
        input  btn_in,
        output db_level,
        output rise_tick,
        output fall_tick
    );
endinterface
`default_nettype wire

// File: rtl/debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pulse
// Description : Synchronises and debounces a raw button, giving a clean level
//               plus single-cycle rise/fall ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_pulse #(
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int CNT_BITS      = $clog2(STABLE_CYCLES)
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    debounce_pulse_if.slave bus
);

    localparam logic [CNT_BITS-1:0] c_cnt_last = CNT_BITS'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_WAIT_HIGH = 2'd1,
        S_HIGH      = 2'd2,
        S_WAIT_LOW  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_BITS-1:0] r_cnt;
    logic [CNT_BITS-1:0] w_cnt_next;
    logic                r_s1;
    logic                r_s2;
    logic                r_db_level;
    logic                r_rise;
    logic                r_fall;
    logic                w_level_next;
    logic                w_rise_next;
    logic                w_fall_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_state    <= S_LOW;
            r_cnt      <= '0;
            r_db_level <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
        end else begin
            r_s1       <= bus.btn_in;
            r_s2       <= r_s1;
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_db_level <= w_level_next;
            r_rise     <= w_rise_next;
            r_fall     <= w_fall_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_LOW: begin
                if (r_s2) begin
                    w_state_next = S_WAIT_HIGH;
                    w_cnt_next   = '0;
                end
            end
            S_WAIT_HIGH: begin
                if (!r_s2) begin
                    w_state_next = S_LOW;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_next = S_HIGH;
                end else begin
                    w_cnt_next = r_cnt + CNT_BITS'(1);
                end
            end
            S_HIGH: begin
                if (!r_s2) begin
                    w_state_next = S_WAIT_LOW;
                    w_cnt_next   = '0;
                end
            end
            S_WAIT_LOW: begin
                if (r_s2) begin
                    w_state_next = S_HIGH;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_next = S_LOW;
                end else begin
                    w_cnt_next = r_cnt + CNT_BITS'(1);
                end
            end
            default: begin
                w_state_next = S_LOW;
                w_cnt_next   = '0;
            end
        endcase

        // Outputs are registered from the next state so they switch on the acceptance edge itself.
        w_level_next = (w_state_next == S_HIGH) || (w_state_next == S_WAIT_LOW);
        w_rise_next  = (r_state == S_WAIT_HIGH) && (w_state_next == S_HIGH);
        w_fall_next  = (r_state == S_WAIT_LOW) && (w_state_next == S_LOW);
    end

    assign bus.db_level  = r_db_level;
    assign bus.rise_tick = r_rise;
    assign bus.fall_tick = r_fall;

endmodule
`default_nettype wire

// File: tb/tb_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_pulse
// Description : Directed and random bounce sequences against a run-length model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_pulse;

    localparam int STABLE = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    debounce_pulse_if bus ();

    debounce_pulse #(.STABLE_CYCLES(STABLE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: input seen two edges late; a level is accepted after STABLE+1
    // consecutive samples that disagree with the current level.
    logic m_p1, m_p2, m_level, m_rise, m_fall;
    int   m_run;

    int       rise_seen;
    int       fall_seen;
    logic [3:0] mod_cnt;
    int       presses;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_p1 = 1'b0; m_p2 = 1'b0; m_level = 1'b0;
        m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
    endtask

    task automatic step(input logic b);
        logic sample;
        bus.btn_in = b;
        @(posedge clk);
        sample = m_p2;
        m_p2   = m_p1;
        m_p1   = b;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (sample != m_level) begin
            m_run++;
            if (m_run == STABLE + 1) begin
                m_level = sample;
                m_rise  = sample;
                m_fall  = ~sample;
                m_run   = 0;
            end
        end else begin
            m_run = 0;
        end
        @(negedge clk);
        check("db_level",  {31'd0, bus.db_level},  {31'd0, m_level});
        check("rise_tick", {31'd0, bus.rise_tick}, {31'd0, m_rise});
        check("fall_tick", {31'd0, bus.fall_tick}, {31'd0, m_fall});
        if (bus.rise_tick === 1'b1) begin
            rise_seen++;
            mod_cnt = (mod_cnt == 4'd9) ? 4'd0 : mod_cnt + 4'd1;
        end
        if (bus.fall_tick === 1'b1) fall_seen++;
    endtask

    task automatic hold_reset(input int cycles);
        reset_n = 1'b0;
        model_clear();
        #1;
        check("reset_async_level", {31'd0, bus.db_level}, 32'd0);
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
            check("reset_hold_outs", {29'd0, bus.db_level, bus.rise_tick, bus.fall_tick}, 32'd0);
        end
        reset_n = 1'b1;
    endtask

    // Hold btn high and return the step index at which rise_tick first appears.
    task automatic measure_rise(output int first);
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1);
            if (bus.rise_tick === 1'b1 && first < 0) first = i;
        end
    endtask

    initial begin
        int first;
        int fall_at;
        int drop_at;
        logic prev_level;

        bus.btn_in = 1'b1;
        rise_seen  = 0;
        fall_seen  = 0;
        mod_cnt    = 4'd0;
        model_clear();

        // Reset while button already high
        @(negedge clk);
        hold_reset(4);
        rise_seen = 0; fall_seen = 0;
        measure_rise(first);
        check("reset_release_latency", first, 7);
        check("reset_release_level", {31'd0, bus.db_level}, 32'd1);
        check("reset_release_rises", rise_seen, 1);

        // Clean press
        repeat (15) step(1'b0);
        rise_seen = 0; fall_seen = 0;
        measure_rise(first);
        check("clean_press_latency", first, 7);
        check("clean_press_rises", rise_seen, 1);
        check("clean_press_falls", fall_seen, 0);

        // Bounce rejection
        repeat (15) step(1'b0);
        rise_seen = 0; fall_seen = 0;
        repeat (5) begin
            repeat (3) step(1'b1);
            step(1'b0);
        end
        check("bounce_level_low", {31'd0, bus.db_level}, 32'd0);
        check("bounce_no_ticks", rise_seen + fall_seen, 0);
        repeat (15) step(1'b1);
        check("bounce_then_hold_rises", rise_seen, 1);

        // Release with bounce
        rise_seen = 0; fall_seen = 0;
        fall_at = -1; drop_at = -1;
        repeat (4) begin
            repeat (2) step(1'b0);
            step(1'b1);
        end
        check("release_bounce_level_high", {31'd0, bus.db_level}, 32'd1);
        for (int i = 0; i < 15; i++) begin
            prev_level = bus.db_level;
            step(1'b0);
            if (bus.fall_tick === 1'b1 && fall_at < 0) fall_at = i;
            if (prev_level === 1'b1 && bus.db_level === 1'b0 && drop_at < 0) drop_at = i;
        end
        check("release_falls", fall_seen, 1);
        check("release_rises", rise_seen, 0);
        check("release_drop_with_tick", drop_at, fall_at);

        // Reset mid-wait (counter at 2 in WAIT_HIGH)
        repeat (5) step(1'b1);
        check("midwait_level_low", {31'd0, bus.db_level}, 32'd0);
        hold_reset(2);
        rise_seen = 0; fall_seen = 0;
        measure_rise(first);
        check("midwait_latency", first, 7);

        // Random bounce segments
        repeat (60) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 8));
            repeat (len) step(v);
        end

        // Integration: bounced presses drive a mod-10 counter
        repeat (15) step(1'b0);
        rise_seen = 0; fall_seen = 0;
        mod_cnt   = 4'd0;
        presses   = 12;
        for (int p = 0; p < presses; p++) begin
            repeat (3) begin
                repeat (int'($urandom_range(1, 3))) step(1'b1);
                repeat (int'($urandom_range(1, 3))) step(1'b0);
            end
            repeat (12) step(1'b1);
            repeat (3) begin
                repeat (int'($urandom_range(1, 3))) step(1'b0);
                repeat (int'($urandom_range(1, 3))) step(1'b1);
            end
            repeat (12) step(1'b0);
        end
        check("integration_rises", rise_seen, presses);
        check("integration_falls", fall_seen, presses);
        check("integration_mod_cnt", {28'd0, mod_cnt}, 32'(presses % 10));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
